// File: rtl/pingpong_pkg.sv
// Shared definitions for the ping-pong sample memory write controller and its reader.
// Holds the writer state encoding and the bank/address geometry constants.
package pingpong_pkg;

  localparam int IDX_BITS  = 7;
  localparam int DATA_BITS = 8;
  localparam int DEPTH     = 2 ** IDX_BITS;
  localparam int ADDR_W    = IDX_BITS + 1;

  typedef enum logic {
    IDLE = 1'b0,
    FILL = 1'b1
  } wr_state_t;

endpackage

// File: rtl/wrap_counter.sv
// Free-running index counter with synchronous active-low clear and enable.
// at_max flags the last index so the owner knows the next increment wraps to zero.
module wrap_counter #(
  parameter int W = 7
) (
  input  logic         clk,
  input  logic         clear_n,
  input  logic         en,
  output logic [W-1:0] count,
  output logic         at_max
);

  always_ff @(posedge clk) begin
    if (!clear_n) begin
      count <= '0;
    end else if (en) begin
      count <= count + 1'b1;
    end
  end

  assign at_max = (count == {W{1'b1}});

endmodule

// File: rtl/pingpong_wr_ctrl.sv
// Write-side controller filling two alternating memory banks from a valid/ready stream.
// Define STALL_CNT_EN to add a saturating stall_cnt output counting refused samples.
module pingpong_wr_ctrl
  import pingpong_pkg::*;
#(
  parameter int DATA_W = DATA_BITS,
  parameter int IDX_W  = IDX_BITS
) (
  input  logic              m_clk,
  input  logic              reset,
  input  logic              in_valid,
  input  logic [DATA_W-1:0] in_data,
  output logic              in_ready,
  output logic              wr_en,
  output logic [IDX_W:0]    wr_addr,
  output logic [DATA_W-1:0] wr_data,
  input  logic              rel_valid,
  output logic [1:0]        bank_full,
  output logic              rd_bank
`ifdef STALL_CNT_EN
  ,
  output logic [15:0]       stall_cnt
`endif
);

  wr_state_t        state;
  wr_state_t        state_next;
  logic [IDX_W-1:0] idx;
  logic             idx_at_max;
  logic             wr_bank;
  logic             transfer;
  logic             commit;
  logic             release_bank;
  logic [1:0]       bank_full_next;

  assign in_ready     = (state == FILL);
  assign transfer     = in_valid & in_ready;
  assign commit       = transfer & idx_at_max;
  assign release_bank = rel_valid & bank_full[rd_bank];

  wrap_counter #(
    .W(IDX_W)
  ) u_idx (
    .clk    (m_clk),
    .clear_n(reset),
    .en     (transfer),
    .count  (idx),
    .at_max (idx_at_max)
  );

  // Commit and release always target different banks, so both edits can be merged.
  always_comb begin
    state_next     = state;
    bank_full_next = bank_full;
    case (state)
      IDLE: if (!bank_full[wr_bank]) state_next = FILL;
      FILL: if (commit) state_next = IDLE;
      default: state_next = IDLE;
    endcase
    if (release_bank) bank_full_next[rd_bank] = 1'b0;
    if (commit)       bank_full_next[wr_bank] = 1'b1;
  end

  always_ff @(posedge m_clk) begin
    if (!reset) begin
      state     <= IDLE;
      wr_bank   <= 1'b0;
      rd_bank   <= 1'b0;
      bank_full <= 2'b00;
      wr_en     <= 1'b0;
      wr_addr   <= '0;
      wr_data   <= '0;
    end else begin
      state     <= state_next;
      bank_full <= bank_full_next;
      wr_en     <= transfer;
      if (transfer) begin
        wr_addr <= {wr_bank, idx};
        wr_data <= in_data;
      end
      if (commit)       wr_bank <= ~wr_bank;
      if (release_bank) rd_bank <= ~rd_bank;
    end
  end

`ifdef STALL_CNT_EN
  // Refused samples only; the count sticks at all-ones rather than wrapping.
  always_ff @(posedge m_clk) begin
    if (!reset) begin
      stall_cnt <= '0;
    end else if (in_valid && !in_ready && (stall_cnt != 16'hFFFF)) begin
      stall_cnt <= stall_cnt + 16'd1;
    end
  end
`endif

endmodule
